mem_line_responder: RTL and testbench

Main-memory side of the cache line-fill and writeback interface. The 4-way set-associative cache controller issues line-granular read (fill) and write (writeback) requests. This block stores lines in an internal word array and answers with DATA_WIDTH-wide bursts. Each burst is critical-word-first with wrap-around. It is the backing store used in cache integration benches and in the first FPGA bring-up.

---
 rtl/mem_line_responder.sv | 172 +++++++++++++++++
 tb/tb_mem_line_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// mem_line_responder: main-memory model behind the cache line-fill / writeback port.
// Lines are held in a flat word array. Every burst is exactly BEATS long and starts at
// the critical word, wrapping around inside the line.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | ready for a request; latches line, start word and clears the beat count
// S_RD_WAIT  | read latency countdown before the first fill beat
// S_RD_BURST | presenting fill beats; advances on valid & ready
// S_WR_BURST | consuming writeback beats; advances on valid & ready
// S_WR_ACK   | one-cycle writeback-committed pulse
module mem_line_responder #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int OFFSET_BITS     = 6,
  parameter int MEM_LINES       = 1024,
  parameter int READ_LATENCY    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic                     i_wdata_valid,
  output logic                     o_wdata_ready,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  output logic                     o_rdata_valid,
  input  logic                     i_rdata_ready,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic                     o_rdata_last,
  output logic                     o_wr_done
);

  localparam int BEATS     = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int LINE_BITS = $clog2(MEM_LINES);
  localparam int LAT_BITS  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int IDX_BITS  = LINE_BITS + BEAT_BITS;

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [LAT_BITS-1:0]  LAT_LOAD  = LAT_BITS'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_BURST = 3'd2,
    S_WR_BURST = 3'd3,
    S_WR_ACK   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LINE_BITS-1:0]   r_line;
  logic [BEAT_BITS-1:0]   r_start;
  logic [BEAT_BITS-1:0]   r_beat;
  logic [LAT_BITS-1:0]    r_lat;
  logic [DATA_WIDTH-1:0]  r_mem [MEM_LINES*BEATS];

  logic [BEAT_BITS-1:0]   w_word;
  logic [IDX_BITS-1:0]    w_mem_idx;
  logic                   w_req_hs;
  logic                   w_wr_hs;
  logic                   w_rd_hs;
  logic                   w_beat_last;
  logic                   w_lat_done;
  logic                   w_unused_addr;

  // Word within the line wraps naturally because BEATS is a power of two.
  assign w_word      = r_start + r_beat;
  assign w_mem_idx   = {r_line, w_word};
  assign w_req_hs    = i_req_valid & o_req_ready;
  assign w_wr_hs     = i_wdata_valid & o_wdata_ready;
  assign w_rd_hs     = o_rdata_valid & i_rdata_ready;
  assign w_beat_last = (r_beat == LAST_BEAT);
  // A latency of N keeps RD_WAIT for N cycles; a latency of 0 still spends one cycle there.
  assign w_lat_done  = (r_lat <= LAT_BITS'(1));
  // Tag and byte-in-word address bits are intentionally ignored (lines alias).
  assign w_unused_addr = ^i_req_addr;

  // Next-state and handshake outputs, decoded from the current state only.
  always_comb begin
    w_state_nxt   = r_state;
    o_req_ready   = 1'b0;
    o_wdata_ready = 1'b0;
    o_rdata_valid = 1'b0;
    o_rdata_last  = 1'b0;
    o_rdata       = '0;
    o_wr_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_state_nxt = i_req_write ? S_WR_BURST : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (w_lat_done) begin
          w_state_nxt = S_RD_BURST;
        end
      end
      S_RD_BURST: begin
        o_rdata_valid = 1'b1;
        o_rdata       = r_mem[w_mem_idx];
        o_rdata_last  = w_beat_last;
        if (i_rdata_ready && w_beat_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_BURST: begin
        o_wdata_ready = 1'b1;
        if (i_wdata_valid && w_beat_last) begin
          w_state_nxt = S_WR_ACK;
        end
      end
      S_WR_ACK: begin
        o_wr_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus request capture, latency countdown and beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_start <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_line  <= i_req_addr[OFFSET_BITS +: LINE_BITS];
            r_start <= i_req_addr[OFFSET_BITS-1 -: BEAT_BITS];
            r_beat  <= '0;
            r_lat   <= LAT_LOAD;
          end
        end
        S_RD_WAIT: begin
          r_lat <= w_lat_done ? '0 : (r_lat - LAT_BITS'(1));
        end
        S_RD_BURST: begin
          if (w_rd_hs) begin
            r_beat <= r_beat + BEAT_BITS'(1);
          end
        end
        S_WR_BURST: begin
          if (w_wr_hs) begin
            r_beat <= r_beat + BEAT_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line storage has no reset; o_wdata_ready is low during reset, so nothing is written then.
  always_ff @(posedge clk) begin
    if (w_wr_hs) begin
      r_mem[w_mem_idx] <= i_wdata;
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: directed scenarios plus randomized
// write/fill traffic checked against a word-addressed memory model.
module tb_mem_line_responder;

  localparam int RL = 4;
  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic        i_wdata_valid = 1'b0;
  logic        o_wdata_ready;
  logic [31:0] i_wdata = '0;
  logic        o_rdata_valid;
  logic        i_rdata_ready = 1'b0;
  logic [31:0] o_rdata;
  logic        o_rdata_last;
  logic        o_wr_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference memory: key = line * NB + word.
  logic [31:0] model [int];

  always #5 clk = ~clk;

  mem_line_responder #(
    .LINE_SIZE_BYTES(64),
    .DATA_WIDTH     (32),
    .ADDRESS_WIDTH  (32),
    .OFFSET_BITS    (6),
    .MEM_LINES      (1024),
    .READ_LATENCY   (RL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_write  (i_req_write),
    .i_req_addr   (i_req_addr),
    .i_wdata_valid(i_wdata_valid),
    .o_wdata_ready(o_wdata_ready),
    .i_wdata      (i_wdata),
    .o_rdata_valid(o_rdata_valid),
    .i_rdata_ready(i_rdata_ready),
    .o_rdata      (o_rdata),
    .o_rdata_last (o_rdata_last),
    .o_wr_done    (o_wr_done)
  );

  function automatic int key_of(input logic [31:0] addr, input int beat);
    int line;
    int start;
    line  = int'((addr >> 6) % 1024);
    start = int'((addr >> 2) % NB);
    return line * NB + ((start + beat) % NB);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writeback of a full line (beat k carries d[k]); abort_at >= 0 pulls reset after that many beats.
  task automatic write_line(input logic [31:0] addr, input logic [31:0] d [NB], input int abort_at);
    int k;
    int guard;
    i_req_valid   = 1'b1;
    i_req_write   = 1'b1;
    i_req_addr    = addr;
    i_wdata_valid = 1'b1;
    i_wdata       = d[0];
    n_cmp++;
    if ({o_req_ready, o_wdata_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL wr_idle_hs: req_ready,wdata_ready=%b expected 10", {o_req_ready, o_wdata_ready});
    end
    tick();
    i_req_valid = 1'b0;
    k = 0;
    guard = 0;
    while (k < NB && guard < 400) begin
      if (k == abort_at) begin
        i_wdata_valid = 1'b1;
        i_wdata       = d[k];
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_req_ready, o_wdata_ready, o_wr_done, o_rdata_valid} !== 4'b1000) begin
          n_err++;
          $display("FAIL abort_idle: rdy,wrdy,done,rvalid=%b expected 1000",
                   {o_req_ready, o_wdata_ready, o_wr_done, o_rdata_valid});
        end
        tick();
        tick();
        i_wdata_valid = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
          tick();
          n_cmp++;
          if ({o_req_ready, o_wdata_ready, o_wr_done} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_after: rdy,wrdy,done=%b expected 100", {o_req_ready, o_wdata_ready, o_wr_done});
          end
        end
        return;
      end
      i_wdata_valid = ($urandom_range(0, 3) != 0);
      i_wdata       = d[k];
      n_cmp++;
      if ({o_wdata_ready, o_wr_done, o_req_ready} !== 3'b100) begin
        n_err++;
        $display("FAIL wr_burst beat %0d: wrdy,done,rdy=%b expected 100", k, {o_wdata_ready, o_wr_done, o_req_ready});
      end
      tick();
      if (i_wdata_valid) begin
        model[key_of(addr, k)] = d[k];
        k++;
      end
      guard++;
    end
    i_wdata_valid = 1'b0;
    if (k < NB) begin
      n_cmp++;
      n_err++;
      $display("FAIL wr_timeout: beats %0d expected %0d", k, NB);
      return;
    end
    n_cmp++;
    if ({o_wdata_ready, o_wr_done, o_req_ready} !== 3'b010) begin
      n_err++;
      $display("FAIL wr_done_pulse: wrdy,done,rdy=%b expected 010", {o_wdata_ready, o_wr_done, o_req_ready});
    end
    tick();
    n_cmp++;
    if ({o_wdata_ready, o_wr_done, o_req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL wr_back_idle: wrdy,done,rdy=%b expected 001", {o_wdata_ready, o_wr_done, o_req_ready});
    end
  endtask

  // Fill of a full line; stalls ready for stall_len samples at beat stall_beat, or randomly when rand_bp.
  task automatic read_line(input logic [31:0] addr, input int stall_beat, input int stall_len, input bit rand_bp);
    int k;
    int lat;
    int stalled;
    int guard;
    int exp_lat;
    logic [31:0] exp_d;
    exp_lat = (RL == 0) ? 1 : RL;
    i_req_valid   = 1'b1;
    i_req_write   = 1'b0;
    i_req_addr    = addr;
    i_rdata_ready = 1'b1;
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rd_req_ready: got %b expected 1", o_req_ready);
    end
    tick();
    i_req_valid = 1'b0;
    lat = 0;
    while (o_rdata_valid !== 1'b1 && lat < 50) begin
      if (o_req_ready !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_wait_ready: got %b expected 0", o_req_ready);
      end
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL rd_latency: got %0d edges expected %0d", lat, exp_lat);
    end
    k = 0;
    stalled = 0;
    guard = 0;
    while (k < NB && guard < 400) begin
      exp_d = model[key_of(addr, k)];
      n_cmp++;
      if (o_rdata_valid !== 1'b1 || o_rdata !== exp_d || o_rdata_last !== (k == NB - 1) || o_req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL rd_beat %0d: valid=%b data=%h last=%b rdy=%b expected 1 %h %b 0",
                 k, o_rdata_valid, o_rdata, o_rdata_last, o_req_ready, exp_d, (k == NB - 1));
      end
      if (k == stall_beat && stalled < stall_len) begin
        i_rdata_ready = 1'b0;
        stalled++;
      end else if (rand_bp) begin
        i_rdata_ready = ($urandom_range(0, 2) != 0);
      end else begin
        i_rdata_ready = 1'b1;
      end
      tick();
      if (i_rdata_ready) k++;
      guard++;
    end
    if (k < NB) begin
      n_cmp++;
      n_err++;
      $display("FAIL rd_timeout: beats %0d expected %0d", k, NB);
    end
    n_cmp++;
    if ({o_rdata_valid, o_req_ready, o_rdata_last} !== 3'b010 || o_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rd_end: valid,rdy,last=%b data=%h expected 010 00000000",
               {o_rdata_valid, o_req_ready, o_rdata_last}, o_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      i_req_valid   = 1'($urandom);
      i_req_write   = 1'($urandom);
      i_req_addr    = $urandom;
      i_wdata_valid = 1'($urandom);
      i_wdata       = $urandom;
      i_rdata_ready = 1'($urandom);
      tick();
      n_cmp++;
      if ({o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata_last, o_wr_done} !== 5'b10000 || o_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL reset_outputs: rdy,wrdy,rvalid,last,done=%b data=%h expected 10000 00000000",
                 {o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata_last, o_wr_done}, o_rdata);
      end
    end
    i_req_valid   = 1'b0;
    i_wdata_valid = 1'b0;
    i_rdata_ready = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: req_ready=%b expected 1", o_req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d [NB];
    for (int k = 0; k < NB; k++) d[k] = 32'hA000_0000 + 32'(k);
    write_line(32'h0000_0040, d, -1);
    read_line(32'h0000_0040, -1, 0, 1'b0);
  endtask

  task automatic test_critical_word();
    n_cmp++;
    if (model[key_of(32'h0000_0074, 0)] !== 32'hA000_000D) begin
      n_err++;
      $display("FAIL cwf_model_word: got %h expected a000000d", model[key_of(32'h0000_0074, 0)]);
    end
    read_line(32'h0000_0074, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    read_line(32'h0000_0040, 5, 3, 1'b0);
  endtask

  task automatic test_alias();
    logic [31:0] d [NB];
    for (int k = 0; k < NB; k++) d[k] = 32'hC0DE_0000 + 32'(k * 3);
    write_line(32'h0001_0000, d, -1);
    n_cmp++;
    if (model[key_of(32'h0000_0000, 4)] !== 32'hC0DE_000C) begin
      n_err++;
      $display("FAIL alias_model: got %h expected c0de000c", model[key_of(32'h0000_0000, 4)]);
    end
    read_line(32'h0000_0000, -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d [NB];
    for (int k = 0; k < NB; k++) d[k] = 32'hB000_0000 + 32'(k);
    write_line(32'h0000_0040, d, 7);
    read_line(32'h0000_0040, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] d [NB];
    logic [31:0] addr;
    int lines [4];
    lines = '{5, 77, 512, 1023};
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NB; k++) d[k] = $urandom;
      addr = ($urandom & 32'hFFFF_0000) | (32'(lines[i]) << 6) | (32'($urandom_range(0, NB - 1)) << 2) | ($urandom & 32'h3);
      write_line(addr, d, -1);
    end
    for (int i = 0; i < 8; i++) begin
      addr = ($urandom & 32'hFFFF_0000) | (32'(lines[$urandom_range(0, 3)]) << 6)
           | (32'($urandom_range(0, NB - 1)) << 2) | ($urandom & 32'h3);
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < NB; k++) d[k] = $urandom;
        write_line(addr, d, -1);
      end
      read_line(addr, $urandom_range(0, NB - 1), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_critical_word();
    test_backpressure();
    test_alias();
    test_reset_mid_write();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
